// File: rtl/fc_pkg.sv
//------------------------------------------------------------------------------
// Module   : fc_pkg
// Brief    : Shared types and constants for the fully-connected layer controllers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fc_pkg;

    localparam int VEC_LEN = 128;
    localparam int BYTE_W  = 8;
    localparam int SUM_W   = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } fc_state_e;

endpackage

`default_nettype wire

// File: rtl/full_connect_2_if.sv
//------------------------------------------------------------------------------
// Module   : full_connect_2_if
// Brief    : ROM/RAM/MultAdder bus of the output fully-connected layer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface full_connect_2_if #(
    parameter int N_OUT = 10
);
    import fc_pkg::*;

    logic                         ena;
    logic [VEC_LEN*BYTE_W-1:0]    data_from_rom;
    logic [VEC_LEN*BYTE_W-1:0]    data_from_ram;
    logic [SUM_W-1:0]             data_from_MultAdder;
    logic                         overflow_from_MultAdder;
    logic                         overflow;
    logic                         done;
    logic [31:0]                  addr_to_rom;
    logic [VEC_LEN*BYTE_W-1:0]    opr1_to_MultAdder;
    logic [VEC_LEN*BYTE_W-1:0]    opr2_to_MultAdder;
    logic [N_OUT*BYTE_W-1:0]      data_to_ram;

    // Controller side
    modport master (
        input  ena,
        input  data_from_rom,
        input  data_from_ram,
        input  data_from_MultAdder,
        input  overflow_from_MultAdder,
        output overflow,
        output done,
        output addr_to_rom,
        output opr1_to_MultAdder,
        output opr2_to_MultAdder,
        output data_to_ram
    );

    // Memory / MAC side
    modport slave (
        output ena,
        output data_from_rom,
        output data_from_ram,
        output data_from_MultAdder,
        output overflow_from_MultAdder,
        input  overflow,
        input  done,
        input  addr_to_rom,
        input  opr1_to_MultAdder,
        input  opr2_to_MultAdder,
        input  data_to_ram
    );

endinterface

`default_nettype wire

// File: rtl/fc_quant.sv
//------------------------------------------------------------------------------
// Module   : fc_quant
// Brief    : MAC sum -> int8: arithmetic shift then saturate. FC2_RELU_EN adds ReLU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fc_quant
    import fc_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic signed [SUM_W-1:0] i_sum,
    output logic        [BYTE_W-1:0] o_q
);

    localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] C_MIN = SUM_W'(-128);

    logic signed [SUM_W-1:0] w_shifted;

    assign w_shifted = i_sum >>> SHIFT;

    always_comb begin
        o_q = w_shifted[BYTE_W-1:0];
`ifdef FC2_RELU_EN
        if (w_shifted < 0) begin
            o_q = '0;
        end else if (w_shifted > C_MAX) begin
            o_q = {1'b0, {(BYTE_W-1){1'b1}}};
        end
`else
        if (w_shifted > C_MAX) begin
            o_q = {1'b0, {(BYTE_W-1){1'b1}}};
        end else if (w_shifted < C_MIN) begin
            o_q = {1'b1, {(BYTE_W-1){1'b0}}};
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/full_connect_2.sv
//------------------------------------------------------------------------------
// Module   : full_connect_2
// Brief    : Output FC layer controller: sequences N_OUT ROM rows through the
//            external MultAdder and packs the int8 results. Option: FC2_RELU_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_connect_2
    import fc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          N_OUT     = 10,
    parameter int          SHIFT     = 2
) (
    input  logic              clk,
    input  logic              iRst_n,
    full_connect_2_if.master  bus
);

    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_OUT - 1);

    fc_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             addr_q, addr_d;
    logic [N_OUT*BYTE_W-1:0] data_q, data_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic [BYTE_W-1:0]       w_q_byte;

    fc_quant #(
        .SHIFT (SHIFT)
    ) u_quant (
        .i_sum (bus.data_from_MultAdder),
        .o_q   (w_q_byte)
    );

    // The MAC operands are the memories themselves; no staging register.
    assign bus.opr1_to_MultAdder = bus.data_from_rom;
    assign bus.opr2_to_MultAdder = bus.data_from_ram;

    assign bus.addr_to_rom = addr_q;
    assign bus.data_to_ram = data_q;
    assign bus.overflow    = ovf_q;
    assign bus.done        = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        // Dropping ena aborts from anywhere; results and overflow stay visible.
        if (!bus.ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                    data_d  = '0;
                    ovf_d   = 1'b0;
                end
                FETCH: begin
                    addr_d  = BASE_ADDR + 32'(idx_q);
                    state_d = MAC;
                end
                MAC: begin
                    data_d[int'(idx_q)*BYTE_W +: BYTE_W] = w_q_byte;
                    ovf_d = ovf_q | bus.overflow_from_MultAdder;
                    if (idx_q == C_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_full_connect_2.sv
//------------------------------------------------------------------------------
// Module   : tb_full_connect_2
// Brief    : Self-checking bench for full_connect_2 (honours FC2_RELU_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_full_connect_2;
    import fc_pkg::*;

    localparam int N_OUT = 10;

    typedef struct {
        logic [14:0] sum;
        logic [7:0]  exp_s;
        logic [7:0]  exp_relu;
    } vec_t;

    logic clk = 1'b0;
    logic iRst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [14:0] sum_tab [N_OUT];
    logic        ovf_tab [N_OUT];
    vec_t        vecs    [10];

    always #5 clk = ~clk;

    full_connect_2_if #(.N_OUT(N_OUT)) bus ();

    full_connect_2 #(
        .BASE_ADDR (32'd0),
        .N_OUT     (N_OUT),
        .SHIFT     (2)
    ) dut (
        .clk    (clk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    // MultAdder stub: the sum depends on which neuron row is addressed.
    always_comb begin
        bus.data_from_MultAdder     = 15'h0;
        bus.overflow_from_MultAdder = 1'b0;
        if (bus.addr_to_rom < 32'd10) begin
            bus.data_from_MultAdder     = sum_tab[bus.addr_to_rom[3:0]];
            bus.overflow_from_MultAdder = ovf_tab[bus.addr_to_rom[3:0]];
        end
    end

    // Reference: floor(s/4), clamp to int8 (and to >=0 with ReLU).
    function automatic logic [7:0] ref_q(input logic [14:0] raw);
        int s;
        int r;
        s = raw[14] ? int'(raw) - 32768 : int'(raw);
        r = s / 4;
        if (s < 0 && (s % 4) != 0) r = r - 1;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`ifdef FC2_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[7:0];
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_all(input logic [14:0] s);
        for (int i = 0; i < N_OUT; i++) begin
            sum_tab[i] = s;
            ovf_tab[i] = 1'b0;
        end
    endtask

    task automatic rand_mem();
        for (int j = 0; j < 32; j++) begin
            bus.data_from_rom[j*32 +: 32] = $urandom;
            bus.data_from_ram[j*32 +: 32] = $urandom;
        end
    endtask

    function automatic logic [79:0] exp_bytes(input int upto);
        logic [79:0] e;
        e = '0;
        for (int i = 0; i <= upto; i++) e[i*8 +: 8] = ref_q(sum_tab[i]);
        return e;
    endfunction

    // Full run from IDLE; leaves ena high in DONE.
    task automatic do_run();
        logic eo;
        eo = 1'b0;
        rand_mem();
        @(negedge clk) bus.ena = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                chk("start_data", bus.data_to_ram, 80'h0);
                chk("start_ovf",  80'(bus.overflow), 80'h0);
                chk("start_done", 80'(bus.done), 80'h0);
            end
            if ((k % 2) == 1 && k < 20) begin
                chk("addr", 80'(bus.addr_to_rom), 80'((k - 1) / 2));
                chk("opr_pass", 80'((bus.opr1_to_MultAdder === bus.data_from_rom) &&
                                    (bus.opr2_to_MultAdder === bus.data_from_ram)), 80'h1);
            end
            if ((k % 2) == 0 && k >= 2) begin
                eo = eo | ovf_tab[(k - 2) / 2];
                chk("partial_data", bus.data_to_ram, exp_bytes((k - 2) / 2));
                chk("partial_ovf",  80'(bus.overflow), 80'(eo));
            end
            if (k == 20) chk("done_early", 80'(bus.done), 80'h0);
            if (k == 21) chk("done_edge21", 80'(bus.done), 80'h1);
        end
    endtask

    task automatic drop_ena();
        logic [79:0] hold;
        logic        hovf;
        hold = bus.data_to_ram;
        hovf = bus.overflow;
        @(negedge clk) bus.ena = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 80'(bus.done), 80'h0);
        chk("idle_data", bus.data_to_ram, hold);
        chk("idle_ovf",  80'(bus.overflow), 80'(hovf));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [7:0] e;
        vecs[0] = '{15'h0143, 8'h50, 8'h50};
        vecs[1] = '{15'h3FFF, 8'h7F, 8'h7F};
        vecs[2] = '{15'h7FF0, 8'hFC, 8'h00};
        vecs[3] = '{15'h4000, 8'h80, 8'h00};
        vecs[4] = '{15'h0000, 8'h00, 8'h00};
        vecs[5] = '{15'h01FF, 8'h7F, 8'h7F};
        vecs[6] = '{15'h0203, 8'h7F, 8'h7F};
        vecs[7] = '{15'h7E01, 8'h80, 8'h00};
        vecs[8] = '{15'h7DFC, 8'h80, 8'h00};
        vecs[9] = '{15'h7FFF, 8'hFF, 8'h00};

        iRst_n = 1'b0;
        bus.ena = 1'b0;
        bus.data_from_rom = '0;
        bus.data_from_ram = '0;
        set_all(15'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 80'(bus.addr_to_rom), 80'h0);
        chk("rst_data", bus.data_to_ram, 80'h0);
        chk("rst_ovf",  80'(bus.overflow), 80'h0);
        chk("rst_done", 80'(bus.done), 80'h0);
        @(negedge clk) iRst_n = 1'b1;

        // Constant-stub table
        for (int v = 0; v < 10; v++) begin
            set_all(vecs[v].sum);
`ifdef FC2_RELU_EN
            e = vecs[v].exp_relu;
`else
            e = vecs[v].exp_s;
`endif
            do_run();
            chk("vec_data", bus.data_to_ram, {10{e}});
            chk("vec_ovf",  80'(bus.overflow), 80'h0);
            drop_ena();
        end

        // Randomised per-neuron sums and overflow flags
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_OUT; i++) begin
                sum_tab[i] = ($urandom_range(0, 2) == 0) ? 15'($urandom_range(0, 1023))
                                                         : 15'($urandom_range(0, 32767));
                ovf_tab[i] = ($urandom_range(0, 9) == 0);
            end
            do_run();
            drop_ena();
        end

        // Overflow only on neuron 4, then hold in DONE while the stub changes
        set_all(15'h0143);
        ovf_tab[4] = 1'b1;
        do_run();
        set_all(15'h3FFF);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", 80'(bus.done), 80'h1);
        chk("hold_addr", 80'(bus.addr_to_rom), 80'd9);
        chk("hold_data", bus.data_to_ram, {10{8'h50}});
        chk("hold_ovf",  80'(bus.overflow), 80'h1);
        drop_ena();

        // Abort during neuron 5, then restart from neuron 0
        set_all(15'h0143);
        ovf_tab[2] = 1'b1;
        rand_mem();
        @(negedge clk) bus.ena = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk) bus.ena = 1'b0;
        @(posedge clk); #1;
        chk("abort_done", 80'(bus.done), 80'h0);
        chk("abort_data", bus.data_to_ram, exp_bytes(4));
        chk("abort_ovf",  80'(bus.overflow), 80'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_keep", bus.data_to_ram, exp_bytes(4));
        set_all(15'h7FF0);
        do_run();
        drop_ena();

        // Asynchronous reset mid-run
        set_all(15'h0143);
        ovf_tab[1] = 1'b1;
        rand_mem();
        @(negedge clk) bus.ena = 1'b1;
        repeat (7) @(posedge clk);
        #3 iRst_n = 1'b0;
        #1;
        chk("mrst_addr", 80'(bus.addr_to_rom), 80'h0);
        chk("mrst_data", bus.data_to_ram, 80'h0);
        chk("mrst_ovf",  80'(bus.overflow), 80'h0);
        chk("mrst_done", 80'(bus.done), 80'h0);
        bus.ena = 1'b0;
        @(negedge clk) iRst_n = 1'b1;
        set_all(15'h01FF);
        do_run();
        drop_ena();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/full_connect_2.md
Name: full_connect_2

Overview:
- Second (output) fully-connected layer controller of the handwritten-digit DNN accelerator.
- Computes 10 output neurons from a 128-element int8 activation vector (layer-1 result held in RAM) and 128-byte int8 weight rows held in ROM.
- Does not multiply itself: for each neuron it routes one ROM row and the RAM vector to the shared external MultAdder (128-way MAC), then captures its 15-bit signed sum.
- Quantizes each sum to int8 and packs the 10 results into an 80-bit word for RAM.

Parameters:
- BASE_ADDR, 0, ROM row index of neuron 0's weights.
- N_OUT, 10, number of output neurons.
- SHIFT, 2, arithmetic right shift applied to the MAC sum before int8 saturation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- ena  in  1  level enable: high starts/holds operation, low aborts and returns to IDLE.
- data_from_rom  in  1024  weight row; byte k = bits [8k+7:8k]; valid the cycle after addr_to_rom changes.
- data_from_ram  in  1024  128 int8 activations, same byte order.
- data_from_MultAdder  in  15  signed MAC sum of the current opr1/opr2; combinational, valid in the same cycle.
- overflow_from_MultAdder  in  1  MAC overflow flag for the current sum.
- overflow  out  1  sticky: any neuron's MAC overflowed during the current run.
- done  out  1  all N_OUT results valid in data_to_ram.
- addr_to_rom  out  32  ROM row address.
- opr1_to_MultAdder  out  1024  equals data_from_rom; combinational passthrough.
- opr2_to_MultAdder  out  1024  equals data_from_ram; combinational passthrough.
- data_to_ram  out  80  neuron i result at bits [8i+7:8i].

Behaviour:
- Reset (async, iRst_n=0):
  - state=IDLE, neuron index=0.
  - addr_to_rom=BASE_ADDR, data_to_ram=0, overflow=0, done=0.
- States: IDLE, FETCH, MAC, DONE.
- IDLE:
  - If ena=1: go to FETCH, set index=0, addr_to_rom=BASE_ADDR, clear overflow, clear data_to_ram.
- FETCH (1 cycle): addr_to_rom=BASE_ADDR+index is registered; ROM data settles. Go to MAC.
- MAC (1 cycle):
  - Capture sum: r = data_from_MultAdder >>> SHIFT (signed 15-bit).
  - Saturate r to [-128,127] and write it to byte[index].
  - overflow |= overflow_from_MultAdder.
  - If index==N_OUT-1: go to DONE. Else increment index and go to FETCH.
- DONE:
  - done=1 while ena stays high.
  - addr_to_rom, data_to_ram and overflow hold their values.
- Latency: 2 cycles per neuron. With default N_OUT=10, done rises on the 21st rising edge after the edge that sampled ena=1 in IDLE.
- ena low in any state: go to IDLE at the next edge and set done=0. data_to_ram and overflow keep their values until the next start.
- A new run needs ena to go low and then high again. A restart always begins at neuron 0.
- Reset mid-run: immediate return to reset values.
- Byte writes to neurons not yet computed never occur; untouched bytes stay 0 during a run.

Optional Feature:
- Macro FC2_RELU_EN.
  - Defined: after shift and saturation, negative results are clamped to 0 (ReLU); output range is [0,127].
  - Undefined: full signed int8 output.
- overflow behaviour is identical in both builds.

Decomposition:
- Shared package fc_pkg holds:
  - the state enum (IDLE/FETCH/MAC/DONE);
  - constants VEC_LEN=128, BYTE_W=8, SUM_W=15.
- Sub-module fc_quant: combinational shift + saturate (+ optional ReLU) from 15-bit sum to int8. Reusable by layer 1.

Test Plan:
- Reset, then ena=1, ROM all 8'h01, RAM all 8'h02, MultAdder stub constant 15'h0143 (323), overflow_from_MultAdder=0
  -> addr_to_rom steps 0..9 every 2 cycles;
  -> opr1=data_from_rom and opr2=data_from_ram every cycle;
  -> data_to_ram={10{8'h50}};
  -> done=1 at edge 21; overflow=0.
- overflow_from_MultAdder=1 only during neuron 4's MAC cycle -> overflow=1 from that edge, held through DONE.
- Stub returns 15'h3FFF -> every byte 8'h7F (saturation). Stub returns 15'h7FF0 (-16) -> 8'hFC, or 8'h00 with FC2_RELU_EN.
- ena dropped during neuron 5 -> IDLE next edge, done=0.
  - Bytes 0..4 are retained while idle.
  - Re-raising ena restarts at addr 0 and clears overflow and data_to_ram.
- iRst_n pulsed low mid-run -> all outputs return to reset values immediately. Normal run follows release.
- ena held high after DONE -> done stays 1; addr_to_rom stays 9; no further captures even if the stub value changes.
